// File: rtl/tblk_pkg.sv
// tblk_pkg: definitions shared by the transport block shaper (Tx) and
// deshaper (Rx).
//   TBLK_SIZE        - default transport block length in bytes
//   deshaper_state_t - control states of the Rx deshaper
package tblk_pkg;

  localparam int TBLK_SIZE = 480;

  typedef enum logic {
    S_DATA  = 1'b0,
    S_FLUSH = 1'b1
  } deshaper_state_t;

endpackage

// File: rtl/transport_block_deshaper.sv
// transport_block_deshaper: splits the demodulated byte stream into blocks of
// size_tblck bytes. It drops the trailing zero padding of each block and
// forwards only payload bytes. At each block boundary it reports the payload
// length.
//
// Ports
//   clk      - clock
//   rst      - asynchronous reset, active low
//   ival     - input byte valid; accepted on ival & oreq
//   idata    - input byte
//   oreq     - ready to upstream
//   ireq     - ready from downstream; output beat completes on oval & ireq
//   oval     - output byte valid (registered)
//   odata    - output payload byte (registered)
//   oblk_end - one-cycle strobe, block closed
//   oblk_len - payload byte count of the closed block, held until next strobe
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_DATA  | accept bytes; zeros are held back as a pending run
// S_FLUSH | a nonzero byte followed a zero run: emit the run, then the byte
module transport_block_deshaper
  import tblk_pkg::*;
#(
  parameter int size_tblck = TBLK_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ival,
  input  logic [7:0]                      idata,
  output logic                            oreq,
  input  logic                            ireq,
  output logic                            oval,
  output logic [7:0]                      odata,
  output logic                            oblk_end,
  output logic [$clog2(size_tblck+1)-1:0] oblk_len
);

  localparam int LW = $clog2(size_tblck + 1);
  localparam logic [LW-1:0] LAST = LW'(size_tblck - 1);

  deshaper_state_t state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] zrun_q, zrun_d;
  logic [LW-1:0] plen_q, plen_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_last_q, hold_last_d;
  logic          oval_q, oval_d;
  logic [7:0]    odata_q, odata_d;
  logic          end_q, end_d;
  logic          slot_free, acc, last;

  // Output register is free when empty or when its beat completes this cycle.
  assign slot_free = ~oval_q | ireq;
  assign oreq      = (state_q == S_DATA) & slot_free & rst;
  assign acc       = ival & oreq;
  assign last      = (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    zrun_d      = zrun_q;
    plen_d      = plen_q;
    len_d       = len_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    oval_d      = oval_q;
    odata_d     = odata_q;
    end_d       = 1'b0;

    if (slot_free) oval_d = 1'b0;

    case (state_q)
      S_DATA: begin
        if (acc) begin
          cnt_d = last ? '0 : cnt_q + 1'b1;
          if (idata == 8'h00) begin
            if (last) begin
              // trailing zero run of this block is padding: discard it
              end_d  = 1'b1;
              len_d  = plen_q;
              plen_d = '0;
              zrun_d = '0;
            end else begin
              zrun_d = zrun_q + 1'b1;
            end
          end else if (zrun_q == '0) begin
            oval_d  = 1'b1;
            odata_d = idata;
            if (last) begin
              end_d  = 1'b1;
              len_d  = plen_q + 1'b1;
              plen_d = '0;
            end else begin
              plen_d = plen_q + 1'b1;
            end
          end else begin
            // The zero run turned out to be payload. The output slot is free
            // now, so the first zero of the run goes out in this same cycle.
            hold_d      = idata;
            hold_last_d = last;
            oval_d      = 1'b1;
            odata_d     = 8'h00;
            zrun_d      = zrun_q - 1'b1;
            plen_d      = plen_q + 1'b1;
            state_d     = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (slot_free) begin
          oval_d = 1'b1;
          if (zrun_q != '0) begin
            odata_d = 8'h00;
            zrun_d  = zrun_q - 1'b1;
            plen_d  = plen_q + 1'b1;
          end else begin
            odata_d = hold_q;
            state_d = S_DATA;
            if (hold_last_q) begin
              end_d  = 1'b1;
              len_d  = plen_q + 1'b1;
              plen_d = '0;
            end else begin
              plen_d = plen_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_DATA;
      cnt_q       <= '0;
      zrun_q      <= '0;
      plen_q      <= '0;
      len_q       <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      oval_q      <= 1'b0;
      odata_q     <= '0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      zrun_q      <= zrun_d;
      plen_q      <= plen_d;
      len_q       <= len_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      oval_q      <= oval_d;
      odata_q     <= odata_d;
      end_q       <= end_d;
    end
  end

  assign oval     = oval_q;
  assign odata    = odata_q;
  assign oblk_end = end_q;
  assign oblk_len = len_q;

endmodule

// File: tb/tb_transport_block_deshaper.sv
module tb_transport_block_deshaper;

  localparam int SZ = 8;
  localparam int LW = $clog2(SZ + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ival;
  logic [7:0]    idata;
  logic          oreq;
  logic          ireq;
  logic          oval;
  logic [7:0]    odata;
  logic          oblk_end;
  logic [LW-1:0] oblk_len;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         gotlen_q[$];
  int         explen_q[$];

  transport_block_deshaper #(.size_tblck(SZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .ival     (ival),
    .idata    (idata),
    .oreq     (oreq),
    .ireq     (ireq),
    .oval     (oval),
    .odata    (odata),
    .oblk_end (oblk_end),
    .oblk_len (oblk_len)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after posedge, so negedge sees values stable for the
  // next active edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (oval === 1'b1 && ireq === 1'b1) got_q.push_back(odata);
      if (oblk_end === 1'b1) gotlen_q.push_back(int'(oblk_len));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte and return 1 ns after the edge that accepts it.
  task automatic send(input logic [7:0] b);
    int tmo;
    tmo   = 0;
    ival  = 1'b1;
    idata = b;
    forever begin
      @(negedge clk);
      if (oreq === 1'b1) break;
      @(posedge clk); #1;
      tmo++;
      if (tmo > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: byte %0h never accepted within 50 cycles", b);
        break;
      end
    end
    @(posedge clk); #1;
    ival = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [7:0] pad_blk[8]  = '{8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] fin_blk[8]  = '{8'h09, 8'h00, 8'h0A, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    rst   = 1'b0;
    ival  = 1'b0;
    idata = 8'h00;
    ireq  = 1'b1;

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_oval", oval, 0);
      chk("rst_odata", odata, 0);
      chk("rst_end", oblk_end, 0);
      chk("rst_len", oblk_len, 0);
      chk("rst_oreq", oreq, 0);
    end
    rst = 1'b1;
    tick();
    chk("rel_oreq", oreq, 1);

    // full block 11..18, 1-cycle latency, end strobe with the last byte
    for (int i = 0; i < 8; i++) begin
      send(8'h11 + 8'(i));
      chk("full_oval", oval, 1);
      chk("full_odata", odata, 8'h11 + 8'(i));
      exp_q.push_back(8'h11 + 8'(i));
      if (i < 7) chk("full_noend", oblk_end, 0);
    end
    chk("full_end", oblk_end, 1);
    chk("full_len", oblk_len, 8);
    explen_q.push_back(8);

    // padded block, follows with no gap
    for (int i = 0; i < 8; i++) begin
      send(pad_blk[i]);
      if (i < 7) chk("pad_noend", oblk_end, 0);
    end
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    chk("pad_end", oblk_end, 1);
    chk("pad_len", oblk_len, 3);
    explen_q.push_back(3);
    tick();
    chk("pad_end_pulse", oblk_end, 0);
    chk("pad_len_held", oblk_len, 3);

    // interior zeros 01 00 00 02 00 00 00 00
    send(8'h01); send(8'h00); send(8'h00); send(8'h02);
    chk("int_z1_oval", oval, 1);
    chk("int_z1_data", odata, 8'h00);
    chk("int_z1_oreq", oreq, 0);
    tick();
    chk("int_z2_data", odata, 8'h00);
    chk("int_z2_oreq", oreq, 0);
    tick();
    chk("int_h_data", odata, 8'h02);
    chk("int_h_oreq", oreq, 1);
    for (int i = 0; i < 4; i++) send(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    chk("int_end", oblk_end, 1);
    chk("int_len", oblk_len, 4);
    explen_q.push_back(4);

    // backpressure mid-block
    send(8'h21); send(8'h22); send(8'h23);
    ireq  = 1'b0;
    ival  = 1'b1;
    idata = 8'h24;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_oval", oval, 1);
      chk("bp_odata", odata, 8'h23);
      chk("bp_oreq", oreq, 0);
    end
    ireq = 1'b1;
    for (int i = 3; i < 8; i++) send(8'h21 + 8'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h21 + 8'(i));
    chk("bp_end", oblk_end, 1);
    chk("bp_len", oblk_len, 8);
    explen_q.push_back(8);

    // all-zero block
    for (int i = 0; i < 8; i++) begin
      send(8'h00);
      if (i > 0) chk("zero_oval", oval, 0);
    end
    chk("zero_end", oblk_end, 1);
    chk("zero_len", oblk_len, 0);
    explen_q.push_back(0);

    // reset in the middle of a flush
    send(8'h05); send(8'h00); send(8'h00); send(8'h07);
    exp_q.push_back(8'h05);
    rst = 1'b0;
    #1;
    chk("mrst_oval", oval, 0);
    chk("mrst_odata", odata, 0);
    chk("mrst_oreq", oreq, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("mrst_rel_oreq", oreq, 1);
    for (int i = 0; i < 8; i++) send(fin_blk[i]);
    exp_q.push_back(8'h09); exp_q.push_back(8'h00);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
    chk("fresh_end", oblk_end, 1);
    chk("fresh_len", oblk_len, 4);
    explen_q.push_back(4);

    tick(); tick(); tick();

    chk("stream_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("stream[%0d]", i), got_q[i], exp_q[i]);
    chk("len_count", gotlen_q.size(), explen_q.size());
    for (int i = 0; i < explen_q.size() && i < gotlen_q.size(); i++)
      chk($sformatf("blk_len[%0d]", i), gotlen_q[i], explen_q[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/transport_block_deshaper.md
# transport_block_deshaper

Receive-side counterpart of the Tx transport block shaper. It takes the demodulated byte stream and splits it into fixed-size transport blocks of `size_tblck` bytes. Within each block it strips the trailing zero-byte padding the transmitter inserted when its source went idle, and forwards only payload bytes to the Rx upper layer. At every block boundary it reports the payload length on a one-cycle strobe.

## Interface
Parameters:
- `size_tblck`, 480: transport block length in bytes.

Ports:
- `clk`, in, 1: single clock domain.
- `rst`, in, 1: asynchronous, active-low reset.
- `ival`, in, 1: input byte valid.
- `idata`, in, 8: input byte.
- `oreq`, out, 1: ready to upstream. An input byte is accepted on `ival & oreq`.
- `ireq`, in, 1: ready from downstream. An output beat completes on `oval & ireq`.
- `oval`, out, 1: output byte valid, registered.
- `odata`, out, 8: output payload byte, registered.
- `oblk_end`, out, 1: one-cycle strobe marking that a block is closed.
- `oblk_len`, out, `$clog2(size_tblck+1)`: payload byte count of the closed block. Valid with `oblk_end` and held until the next strobe.

## Operation
- `cnt_block` counts accepted input bytes, 0..`size_tblck`-1, and wraps to 0 after the last byte of a block.
- `zrun` (width `$clog2(size_tblck+1)`) counts consecutive zero bytes not yet forwarded. `plen` counts payload bytes forwarded in the current block.
- Protocol rule: padding is only ever a trailing zero run. Any zero run followed by a nonzero byte in the same block is payload and must be emitted.
- FSM states:
  - `S_DATA` (reset state):
    - Zero byte accepted: not forwarded, `zrun++`.
    - Nonzero byte with `zrun==0`: loaded into the output register, `plen++`.
    - Nonzero byte with `zrun>0`: captured into the hold register, go to `S_FLUSH`.
  - `S_FLUSH`: `oreq`=0. Emit one `00` per free output slot, `zrun--`, `plen++`. When `zrun==0`, load the hold byte, `plen++`, and return to `S_DATA`.
- Block close, on the last byte of a block:
  - If that byte is zero: `oblk_end` fires with `oblk_len = plen` and the pending `zrun` is discarded.
  - If that byte is nonzero: `oblk_end` fires once that byte has been loaded into the output register, with `oblk_len` equal to the full payload count.
  - After either case, `plen`, `zrun` and `cnt_block` clear.
- An all-zero block gives `oblk_len`=0 and produces no output beats.
- Reset (mid-block included):
  - All counters clear, FSM returns to `S_DATA`, hold byte dropped.
  - Output reset values: `oval`=0, `odata`=0, `oblk_end`=0, `oblk_len`=0, `oreq`=0 while `rst`=0.

## Timing
- `oreq = (state==S_DATA) & (~oval | ireq) & rst`.
- Pass-through latency is 1 cycle: a byte accepted at cycle N is on `oval`/`odata` at N+1.
- With `oval`=1 and `ireq`=0, `odata` holds stable and no new byte is accepted.
- Flush of `k` zeros with `ireq` held at 1:
  - The hold byte is accepted at N.
  - Zeros appear at N+1..N+k and the hold byte at N+k+1.
  - `oreq` is 0 for cycles N+1..N+k and is 1 again at N+k+1.
- `oblk_end` timing:
  - Zero last byte: asserts at N+1 after its acceptance.
  - Nonzero last byte: asserts in the same cycle that byte's `oval` first goes high.
- A block's last byte and the next block's first byte may be accepted on consecutive cycles with no gap.

## Structure
- Shared package `tblk_pkg` holds:
  - the `TBLK_SIZE` default (480), shared with the Tx shaper;
  - the state enum `deshaper_state_t {S_DATA, S_FLUSH}`.
- No sub-module is required. The output register/skid stage stays inline.

## Test plan
All scenarios use `size_tblck`=8 with `ireq`=1 unless stated.
- Reset: hold `rst`=0 for 3 cycles → all outputs 0. Release → `oreq`=1 on the next cycle.
- Full block `11..18` → output `11..18`, each 1 cycle after acceptance. `oblk_end`=1 with `oblk_len`=8 in the same cycle `18` is presented.
- Padded block `A1 A2 A3 00 00 00 00 00` → output `A1 A2 A3` only. `oblk_end` with `oblk_len`=3 one cycle after the last `00`.
- Interior zeros `01 00 00 02 00 00 00 00` → output `01 00 00 02`. `oreq` is low for 2 cycles after `02` is accepted. `oblk_len`=4.
- Backpressure: drop `ireq` for 3 cycles mid-block → `odata` stable, `oreq`=0, no byte lost or duplicated. Then an all-zero block → `oblk_len`=0 with no `oval`.
- Reset mid-flush after `05 00 00 07` → counters clear. The next 8 bytes form a fresh block with a correct `oblk_len`.
